// File: rtl/pid_pkg.sv
// Shared types and default sizing for the PID controller.
package pid_pkg;

   // Sequencer states, one multiplier pass per gain.
   typedef enum logic [2:0] {
      S_IDLE,
      S_ERR,
      S_MUL_P,
      S_MUL_I,
      S_MUL_D,
      S_SUM,
      S_OUT
   } pid_state_t;

   localparam int PID_REF_W     = 12;
   localparam int PID_FB_W      = 13;
   localparam int PID_GAIN_W    = 8;
   localparam int PID_FRAC_BITS = 4;
   localparam int PID_OUT_W     = 12;
   localparam int PID_ACC_W     = 24;

endpackage

// File: rtl/pid_mult_unit.sv
// Registered signed x unsigned multiply, scaled down by the gain fraction bits.
module pid_mult_unit #(
   parameter int A_W       = 15,
   parameter int GAIN_W    = 8,
   parameter int FRAC_BITS = 4,
   parameter int ACC_W     = 24
) (
   input  logic                    i_clk,
   input  logic                    i_n_reset,
   input  logic signed [A_W-1:0]   i_a,
   input  logic [GAIN_W-1:0]       i_b,
   output logic signed [ACC_W-1:0] o_res
);

   localparam int P_W = A_W + GAIN_W + 1;
   localparam int X_W = (P_W > ACC_W) ? P_W : ACC_W;

   logic signed [X_W-1:0]   a_x;
   logic signed [X_W-1:0]   b_x;
   logic signed [X_W-1:0]   prod;
   logic signed [X_W-1:0]   shifted;
   logic signed [ACC_W-1:0] res_d;
   logic signed [ACC_W-1:0] res_q;

   // Widen both operands (gain is zero-extended), multiply, arithmetic shift.
   always_comb begin
      a_x     = X_W'(i_a);
      b_x     = X_W'(i_b);
      prod    = a_x * b_x;
      shifted = prod >>> FRAC_BITS;
      res_d   = shifted[ACC_W-1:0];
   end

   // Product register: result is available one cycle after the operands.
   always_ff @(posedge i_clk or negedge i_n_reset) begin
      if (!i_n_reset) begin
         res_q <= '0;
      end else begin
         res_q <= res_d;
      end
   end

   assign o_res = res_q;

endmodule

// File: rtl/pid_controller.sv
// Sequential PID controller sharing one multiplier across P, I and D terms.
//
//   state  | meaning
//   IDLE   | waiting for an enabled sample strobe
//   ERR    | e = ref - plant, de = e - e_prev
//   MUL_P  | multiplier fed Kp*e
//   MUL_I  | multiplier fed Ki*e, P captured
//   MUL_D  | multiplier fed Kd*de, integrator updated
//   SUM    | P + I + D clamped to the output range
//   OUT    | outputs registered, valid pulsed
module pid_controller
   import pid_pkg::*;
#(
   parameter int REF_W     = PID_REF_W,
   parameter int FB_W      = PID_FB_W,
   parameter int GAIN_W    = PID_GAIN_W,
   parameter int FRAC_BITS = PID_FRAC_BITS,
   parameter int OUT_W     = PID_OUT_W,
   parameter int ACC_W     = PID_ACC_W
) (
   input  logic                    i_clk,
   input  logic                    i_n_reset,
   input  logic                    i_enable_control,
   input  logic                    i_sample_valid,
   input  logic                    i_clear_integral,
   input  logic [GAIN_W-1:0]       i_p_gain,
   input  logic [GAIN_W-1:0]       i_i_gain,
   input  logic [GAIN_W-1:0]       i_d_gain,
   input  logic [REF_W-1:0]        i_reference,
   input  logic [FB_W-1:0]         i_plant_output,
   output logic [OUT_W-1:0]        o_control_input,
   output logic                    o_control_valid,
   output logic signed [FB_W+1:0]  o_error,
   output logic signed [ACC_W-1:0] o_p_term,
   output logic signed [ACC_W-1:0] o_i_term,
   output logic signed [ACC_W-1:0] o_d_term,
   output logic                    o_saturated,
   output logic                    o_overrun,
   output logic                    o_busy
);

   localparam int E_W = FB_W + 2;
   localparam int S_W = ACC_W + 2;

   localparam logic signed [ACC_W:0] I_MAX = {2'b00, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] I_MIN = -I_MAX;
   localparam logic signed [S_W-1:0] O_MAX = {{(S_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

   pid_state_t state_q, state_d;

   logic [REF_W-1:0]        ref_q, ref_d;
   logic [FB_W-1:0]         plant_q, plant_d;
   logic signed [E_W-1:0]   e_q, e_d;
   logic signed [E_W-1:0]   de_q, de_d;
   logic signed [E_W-1:0]   e_prev_q, e_prev_d;
   logic signed [ACC_W-1:0] p_q, p_d;
   logic signed [ACC_W-1:0] i_acc_q, i_acc_d;
   logic signed [ACC_W-1:0] i_pend_q, i_pend_d;
   logic signed [ACC_W-1:0] d_pend_q, d_pend_d;
   logic [OUT_W-1:0]        ctrl_pend_q, ctrl_pend_d;
   logic                    hi_pend_q, hi_pend_d;
   logic                    lo_pend_q, lo_pend_d;

   logic [OUT_W-1:0]        ctrl_q, ctrl_d;
   logic                    valid_q, valid_d;
   logic signed [E_W-1:0]   err_out_q, err_out_d;
   logic signed [ACC_W-1:0] p_out_q, p_out_d;
   logic signed [ACC_W-1:0] i_out_q, i_out_d;
   logic signed [ACC_W-1:0] d_out_q, d_out_d;
   logic                    sat_hi_q, sat_hi_d;
   logic                    sat_lo_q, sat_lo_d;
   logic                    overrun_q, overrun_d;

   logic signed [E_W-1:0]   mult_a;
   logic [GAIN_W-1:0]       mult_b;
   logic signed [ACC_W-1:0] mult_res;

   logic signed [E_W-1:0]   ref_x;
   logic signed [E_W-1:0]   plant_x;
   logic signed [E_W-1:0]   e_calc;
   logic signed [E_W-1:0]   de_calc;
   logic signed [ACC_W:0]   i_sum;
   logic signed [ACC_W-1:0] i_clamped;
   logic                    skip_i;
   logic signed [S_W-1:0]   sum_calc;
   logic [OUT_W-1:0]        sum_ctrl;
   logic                    sum_hi;
   logic                    sum_lo;

   pid_mult_unit #(
      .A_W       (E_W),
      .GAIN_W    (GAIN_W),
      .FRAC_BITS (FRAC_BITS),
      .ACC_W     (ACC_W)
   ) u_mult (
      .i_clk     (i_clk),
      .i_n_reset (i_n_reset),
      .i_a       (mult_a),
      .i_b       (mult_b),
      .o_res     (mult_res)
   );

   // Datapath arithmetic shared by the state decode below.
   always_comb begin
      ref_x   = E_W'(ref_q);
      plant_x = E_W'(plant_q);
      e_calc  = ref_x - plant_x;
      de_calc = e_calc - e_prev_q;

      i_sum = (ACC_W+1)'(i_acc_q) + (ACC_W+1)'(mult_res);
      if (i_sum > I_MAX) begin
         i_clamped = I_MAX[ACC_W-1:0];
      end else if (i_sum < I_MIN) begin
         i_clamped = I_MIN[ACC_W-1:0];
      end else begin
         i_clamped = i_sum[ACC_W-1:0];
      end

      // Hold the integrator while the output is pinned and e pushes further out.
      skip_i = (sat_hi_q && !e_q[E_W-1] && (e_q != '0)) || (sat_lo_q && e_q[E_W-1]);

      // In SUM the multiplier register holds the D product.
      sum_calc = S_W'(p_q) + S_W'(i_acc_q) + S_W'(mult_res);
      sum_hi   = 1'b0;
      sum_lo   = 1'b0;
      if (sum_calc > O_MAX) begin
         sum_ctrl = '1;
         sum_hi   = 1'b1;
      end else if (sum_calc[S_W-1]) begin
         sum_ctrl = '0;
         sum_lo   = 1'b1;
      end else begin
         sum_ctrl = sum_calc[OUT_W-1:0];
      end
   end

   // Next-state, multiplier operand select and register updates.
   always_comb begin
      state_d     = state_q;
      ref_d       = ref_q;
      plant_d     = plant_q;
      e_d         = e_q;
      de_d        = de_q;
      e_prev_d    = e_prev_q;
      p_d         = p_q;
      i_acc_d     = i_acc_q;
      i_pend_d    = i_pend_q;
      d_pend_d    = d_pend_q;
      ctrl_pend_d = ctrl_pend_q;
      hi_pend_d   = hi_pend_q;
      lo_pend_d   = lo_pend_q;
      ctrl_d      = ctrl_q;
      valid_d     = 1'b0;
      err_out_d   = err_out_q;
      p_out_d     = p_out_q;
      i_out_d     = i_out_q;
      d_out_d     = d_out_q;
      sat_hi_d    = sat_hi_q;
      sat_lo_d    = sat_lo_q;
      overrun_d   = overrun_q;
      mult_a      = '0;
      mult_b      = '0;

      case (state_q)
         S_IDLE: begin
            if (i_sample_valid && i_enable_control) begin
               ref_d   = i_reference;
               plant_d = i_plant_output;
               state_d = S_ERR;
            end
         end
         S_ERR: begin
            e_d      = e_calc;
            de_d     = de_calc;
            e_prev_d = e_calc;
            state_d  = S_MUL_P;
         end
         S_MUL_P: begin
            mult_a  = e_q;
            mult_b  = i_p_gain;
            state_d = S_MUL_I;
         end
         S_MUL_I: begin
            mult_a  = e_q;
            mult_b  = i_i_gain;
            p_d     = mult_res;
            state_d = S_MUL_D;
         end
         S_MUL_D: begin
            mult_a  = de_q;
            mult_b  = i_d_gain;
            if (!skip_i) begin
               i_acc_d = i_clamped;
            end
            state_d = S_SUM;
         end
         S_SUM: begin
            d_pend_d    = mult_res;
            i_pend_d    = i_acc_q;
            ctrl_pend_d = sum_ctrl;
            hi_pend_d   = sum_hi;
            lo_pend_d   = sum_lo;
            state_d     = S_OUT;
         end
         S_OUT: begin
            ctrl_d    = ctrl_pend_q;
            sat_hi_d  = hi_pend_q;
            sat_lo_d  = lo_pend_q;
            err_out_d = e_q;
            p_out_d   = p_q;
            i_out_d   = i_pend_q;
            d_out_d   = d_pend_q;
            valid_d   = 1'b1;
            state_d   = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (i_sample_valid && (state_q != S_IDLE)) begin
         overrun_d = 1'b1;
      end

      // Clear takes priority over an integrator update on the same edge.
      if (i_clear_integral) begin
         i_acc_d   = '0;
         e_prev_d  = '0;
         overrun_d = 1'b0;
      end
   end

   // State and datapath registers.
   always_ff @(posedge i_clk or negedge i_n_reset) begin
      if (!i_n_reset) begin
         state_q     <= S_IDLE;
         ref_q       <= '0;
         plant_q     <= '0;
         e_q         <= '0;
         de_q        <= '0;
         e_prev_q    <= '0;
         p_q         <= '0;
         i_acc_q     <= '0;
         i_pend_q    <= '0;
         d_pend_q    <= '0;
         ctrl_pend_q <= '0;
         hi_pend_q   <= 1'b0;
         lo_pend_q   <= 1'b0;
         ctrl_q      <= '0;
         valid_q     <= 1'b0;
         err_out_q   <= '0;
         p_out_q     <= '0;
         i_out_q     <= '0;
         d_out_q     <= '0;
         sat_hi_q    <= 1'b0;
         sat_lo_q    <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ref_q       <= ref_d;
         plant_q     <= plant_d;
         e_q         <= e_d;
         de_q        <= de_d;
         e_prev_q    <= e_prev_d;
         p_q         <= p_d;
         i_acc_q     <= i_acc_d;
         i_pend_q    <= i_pend_d;
         d_pend_q    <= d_pend_d;
         ctrl_pend_q <= ctrl_pend_d;
         hi_pend_q   <= hi_pend_d;
         lo_pend_q   <= lo_pend_d;
         ctrl_q      <= ctrl_d;
         valid_q     <= valid_d;
         err_out_q   <= err_out_d;
         p_out_q     <= p_out_d;
         i_out_q     <= i_out_d;
         d_out_q     <= d_out_d;
         sat_hi_q    <= sat_hi_d;
         sat_lo_q    <= sat_lo_d;
         overrun_q   <= overrun_d;
      end
   end

   assign o_control_input = ctrl_q;
   assign o_control_valid = valid_q;
   assign o_error         = err_out_q;
   assign o_p_term        = p_out_q;
   assign o_i_term        = i_out_q;
   assign o_d_term        = d_out_q;
   assign o_saturated     = sat_hi_q | sat_lo_q;
   assign o_overrun       = overrun_q;
   assign o_busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_pid_controller.sv
// Self-checking bench for pid_controller: timeline reference model plus directed cases.
module tb_pid_controller;

   localparam int     FRAC  = 4;
   localparam int     ACC_W = 24;
   localparam int     OUT_W = 12;
   localparam longint I_LIM = (longint'(1) << (ACC_W-1)) - 1;
   localparam longint O_LIM = (longint'(1) << OUT_W) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic enable = 1'b0;
   logic valid = 1'b0;
   logic clear = 1'b0;
   logic [7:0]  kp = '0, ki = '0, kd = '0;
   logic [11:0] ref_v = '0;
   logic [12:0] plant_v = '0;

   logic [11:0]        ctrl;
   logic               ctrl_valid;
   logic signed [14:0] err;
   logic signed [23:0] p_term, i_term, d_term;
   logic               sat, ovr, busy;

   pid_controller dut (
      .i_clk            (clk),
      .i_n_reset        (rst_n),
      .i_enable_control (enable),
      .i_sample_valid   (valid),
      .i_clear_integral (clear),
      .i_p_gain         (kp),
      .i_i_gain         (ki),
      .i_d_gain         (kd),
      .i_reference      (ref_v),
      .i_plant_output   (plant_v),
      .o_control_input  (ctrl),
      .o_control_valid  (ctrl_valid),
      .o_error          (err),
      .o_p_term         (p_term),
      .o_i_term         (i_term),
      .o_d_term         (d_term),
      .o_saturated      (sat),
      .o_overrun        (ovr),
      .o_busy           (busy)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: a sample accepted on edge 0 updates e_prev on edge 1,
   // the integrator on edge 4, forms the sum on edge 5 and publishes on edge 6.
   bit     m_active, m_valid, m_ovr, m_sat_hi, m_sat_lo, pend_hi, pend_lo;
   int     m_age;
   longint m_e, m_de, m_eprev, m_iacc;
   longint m_ctrl, m_err, m_p, m_i, m_d;
   longint pend_ctrl, pend_p, pend_i, pend_d;

   always @(posedge clk or negedge rst_n) begin : model
      longint t;
      if (!rst_n) begin
         m_active = 0; m_valid = 0; m_ovr = 0; m_sat_hi = 0; m_sat_lo = 0;
         pend_hi = 0; pend_lo = 0; m_age = 0;
         m_e = 0; m_de = 0; m_eprev = 0; m_iacc = 0;
         m_ctrl = 0; m_err = 0; m_p = 0; m_i = 0; m_d = 0;
         pend_ctrl = 0; pend_p = 0; pend_i = 0; pend_d = 0;
      end else begin
         m_valid = 0;
         if (m_active) begin
            if (valid) m_ovr = 1;
            m_age++;
            if (m_age == 1) begin
               m_de    = m_e - m_eprev;
               m_eprev = m_e;
            end else if (m_age == 4) begin
               if (!((m_sat_hi && m_e > 0) || (m_sat_lo && m_e < 0))) begin
                  t = m_iacc + ((longint'(ki) * m_e) >>> FRAC);
                  if (t > I_LIM) t = I_LIM;
                  else if (t < -I_LIM) t = -I_LIM;
                  m_iacc = t;
               end
            end else if (m_age == 5) begin
               pend_p = (longint'(kp) * m_e) >>> FRAC;
               pend_d = (longint'(kd) * m_de) >>> FRAC;
               pend_i = m_iacc;
               t = pend_p + pend_i + pend_d;
               pend_hi = (t > O_LIM);
               pend_lo = (t < 0);
               pend_ctrl = pend_hi ? O_LIM : (pend_lo ? 0 : t);
            end else if (m_age == 6) begin
               m_ctrl = pend_ctrl; m_p = pend_p; m_i = pend_i; m_d = pend_d;
               m_err = m_e; m_sat_hi = pend_hi; m_sat_lo = pend_lo;
               m_valid = 1; m_active = 0;
            end
         end else if (valid && enable) begin
            m_e = longint'(ref_v) - longint'(plant_v);
            m_active = 1;
            m_age = 0;
         end
         if (clear) begin
            m_iacc = 0; m_eprev = 0; m_ovr = 0;
         end
      end
   end

   // Compare every output against the model on each falling edge.
   always @(negedge clk) begin
      chk("valid", ctrl_valid, m_valid);
      chk("busy", busy, m_active);
      chk("overrun", ovr, m_ovr);
      chk("control", ctrl, m_ctrl);
      chk("error", err, m_err);
      chk("p_term", p_term, m_p);
      chk("i_term", i_term, m_i);
      chk("d_term", d_term, m_d);
      chk("saturated", sat, m_sat_hi | m_sat_lo);
   end

   task automatic wait_valid(input int acc, output int lat);
      lat = -1;
      for (int n = 0; n < 20; n++) begin
         if (ctrl_valid) begin
            lat = cyc - acc;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic apply_sample(input int r, input int p, output int lat);
      int acc;
      @(negedge clk);
      ref_v = 12'(r); plant_v = 13'(p); valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      acc = cyc;
      wait_valid(acc, lat);
   endtask

   task automatic do_clear();
      @(negedge clk); clear = 1'b1;
      @(negedge clk); clear = 1'b0;
   endtask

   initial begin
      int lat, acc, cnt;

      repeat (3) @(negedge clk);
      chk("rst_control", ctrl, 0);
      chk("rst_valid", ctrl_valid, 0);
      chk("rst_busy", busy, 0);
      @(posedge clk); #2 rst_n = 1'b1;
      enable = 1'b1;

      // Pure proportional
      kp = 8'd16;
      apply_sample(500, 0, lat);
      chk("p_latency", lat, 6);
      chk("p_out", ctrl, 500);
      chk("p_sat", sat, 0);

      // Pure integral accumulates
      do_clear(); kp = 8'd0; ki = 8'd16;
      apply_sample(100, 0, lat); chk("i_out1", ctrl, 100);
      apply_sample(100, 0, lat); chk("i_out2", ctrl, 200);
      apply_sample(100, 0, lat); chk("i_out3", ctrl, 300);
      chk("i_term3", i_term, 300);

      // High saturation then anti-windup
      do_clear(); ki = 8'd0; kp = 8'd255;
      apply_sample(4095, 0, lat);
      chk("sat_hi_out", ctrl, 4095);
      chk("sat_hi_flag", sat, 1);
      ki = 8'd16;
      apply_sample(4095, 0, lat);
      chk("windup_i_term", i_term, 0);
      chk("windup_out", ctrl, 4095);

      // Low saturation
      do_clear(); ki = 8'd0; kp = 8'd16;
      apply_sample(0, 500, lat);
      chk("sat_lo_out", ctrl, 0);
      chk("sat_lo_flag", sat, 1);
      chk("sat_lo_err", err, -500);

      // Derivative on a reference step
      do_clear(); kp = 8'd0; kd = 8'd16;
      apply_sample(0, 0, lat);   chk("d_term1", d_term, 0);
      apply_sample(100, 0, lat); chk("d_term2", d_term, 100);
      apply_sample(100, 0, lat); chk("d_term3", d_term, 0);

      // Disabled sample ignored
      enable = 1'b0;
      apply_sample(300, 0, lat);
      chk("disabled_ignored", lat, -1);
      enable = 1'b1;

      // Overrun: second strobe three cycles after the first
      do_clear(); kd = 8'd0; kp = 8'd16;
      @(negedge clk); ref_v = 12'd500; plant_v = '0; valid = 1'b1;
      @(negedge clk); valid = 1'b0; acc = cyc;
      @(negedge clk);
      @(negedge clk); ref_v = 12'd1000; valid = 1'b1;
      @(negedge clk); valid = 1'b0;
      wait_valid(acc, lat);
      chk("ovr_latency", lat, 6);
      chk("ovr_out", ctrl, 500);
      chk("ovr_flag", ovr, 1);
      do_clear();
      @(negedge clk);
      chk("ovr_cleared", ovr, 0);

      // Reset three cycles into a computation
      @(negedge clk); ref_v = 12'd700; valid = 1'b1;
      @(negedge clk); valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk("rst_mid_ctrl", ctrl, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_pterm", p_term, 0);
      @(posedge clk); #2 rst_n = 1'b1;
      cnt = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (ctrl_valid) cnt++;
      end
      chk("rst_mid_no_valid", cnt, 0);

      // Randomised traffic
      for (int it = 0; it < 40; it++) begin
         @(negedge clk);
         valid = 1'b0; clear = 1'b0; enable = 1'b1;
         repeat (8) @(negedge clk);
         if (it % 4 == 0) begin
            kp = 8'($urandom_range(0, 255));
            ki = 8'($urandom_range(0, 255));
            kd = 8'($urandom_range(0, 255));
         end else begin
            kp = 8'($urandom_range(0, 40));
            ki = 8'($urandom_range(0, 40));
            kd = 8'($urandom_range(0, 40));
         end
         for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            ref_v   = 12'($urandom_range(0, 4095));
            plant_v = 13'($urandom_range(0, (c % 5 == 0) ? 8191 : 4095));
            valid   = ($urandom_range(0, 99) < 30);
            enable  = ($urandom_range(0, 99) < 88);
            clear   = ($urandom_range(0, 99) < 3);
         end
      end
      @(negedge clk);
      valid = 1'b0; clear = 1'b0;
      repeat (10) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pid_controller.md
PID_CONTROLLER -- requirements
Module: pid_controller

Interface
REQ-001 Parameter REF_W, default 12: reference width, unsigned.
REQ-002 Parameter FB_W, default 13: plant-output width, unsigned.
REQ-003 Parameter GAIN_W, default 8: gain width, unsigned.
REQ-004 Parameter FRAC_BITS, default 4: gain fractional bits; 16 equals a gain of 1.0.
REQ-005 Parameter OUT_W, default 12: control-output width, unsigned.
REQ-006 Parameter ACC_W, default 24: term and integrator width, signed.
REQ-007 The block SHALL use one clock, i_clk, and an asynchronous active-low reset, i_n_reset.
REQ-008 Ports (clock and reset first):
- i_clk  in  1  clock
- i_n_reset  in  1  asynchronous active-low reset
- i_enable_control  in  1  enables control
- i_sample_valid  in  1  one-cycle new-sample strobe
- i_clear_integral  in  1  synchronous integrator and overrun clear
- i_p_gain / i_i_gain / i_d_gain  in  GAIN_W  gains
- i_reference  in  REF_W  setpoint
- i_plant_output  in  FB_W  feedback
- o_control_input  out  OUT_W  saturated control output
- o_control_valid  out  1  one-cycle pulse when a new output is written
- o_error  out  FB_W+2 signed  last error
- o_p_term / o_i_term / o_d_term  out  ACC_W signed  term values
- o_saturated  out  1  last output clamped
- o_overrun  out  1  sticky: sample dropped while busy
- o_busy  out  1  FSM not IDLE

Function
REQ-009 FSM states SHALL be IDLE, ERR, MUL_P, MUL_I, MUL_D, SUM, OUT.
REQ-010 In IDLE, i_sample_valid=1 with i_enable_control=1 SHALL capture i_reference and i_plant_output and go to ERR.
REQ-011 In IDLE, a sample arriving with i_enable_control=0 SHALL be ignored.
REQ-012 ERR SHALL compute e = ref − plant (signed, FB_W+2 bits) and de = e − e_prev, where e_prev is the previous sample's e.
REQ-013 MUL_P, MUL_I and MUL_D SHALL each use the single shared multiplier once, in that order.
REQ-014 Each product SHALL be arithmetically right-shifted by FRAC_BITS and sign-extended to ACC_W.
- P = (Kp·e) >>> FRAC_BITS
- D = (Kd·de) >>> FRAC_BITS
- I_acc += (Ki·e) >>> FRAC_BITS, clamped to ±(2^(ACC_W−1)−1)
REQ-015 Anti-windup: the I_acc update SHALL be skipped when the previous output saturated high and e>0, or saturated low and e<0.
REQ-016 SUM SHALL form P+I_acc+D at ACC_W+2 bits and clamp it to [0, 2^OUT_W−1]; o_saturated SHALL be set when clamping occurs.
REQ-017 OUT SHALL register o_control_input and the term outputs, pulse o_control_valid, and return to IDLE.
REQ-018 Latency SHALL be exactly 6 cycles from the sampling edge to the o_control_valid edge; the minimum spacing between accepted samples is 7 cycles.
REQ-019 i_sample_valid while o_busy=1 SHALL be dropped and SHALL set o_overrun; the computation in progress SHALL be unaffected.
REQ-020 i_clear_integral SHALL zero I_acc, e_prev and o_overrun on the next edge.
REQ-021 If i_clear_integral coincides with the I update, the clear SHALL win.
REQ-022 Deasserting i_enable_control mid-computation SHALL let the current computation finish; subsequent samples SHALL be ignored.
REQ-023 The first sample after reset or clear SHALL use e_prev=0.

Reset
REQ-024 Asynchronous i_n_reset=0 SHALL force the FSM to IDLE and zero every output, I_acc, e_prev and captured inputs, including mid-computation.
REQ-025 No o_control_valid SHALL be emitted for a computation that reset aborts.

Structure
REQ-026 Package pid_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-027 Sub-module pid_mult_unit SHALL implement the registered signed×unsigned multiply and shift, with 1-cycle latency.

Verification
REQ-028 With Kp=16, Ki=Kd=0, ref=500, plant=0 and one sample: o_control_input=500 with o_control_valid exactly 6 cycles later and o_saturated=0.
REQ-029 With Ki=16, Kp=Kd=0, ref=100, plant=0 and three spaced samples: outputs SHALL be 100, 200, 300.
REQ-030 With Kp=255, ref=4095, plant=0: output 4095 and o_saturated=1. Then Ki=16 and a further sample: o_i_term SHALL stay unchanged (anti-windup).
REQ-031 With Kp=16, ref=0, plant=500: output 0, o_saturated=1 and o_error=−500.
REQ-032 With Kd=16, plant=0, ref stepping 0→100→100: o_d_term SHALL be 0, then 100, then 0.
REQ-033 A second sample 3 cycles after the first SHALL be dropped and set o_overrun=1; reset asserted at cycle 3 SHALL give no valid pulse and all outputs 0.
